// File: rtl/fpadd_result_display.sv
// Result display stage: buffers 32-bit FP results in a FIFO and shows each word byte by byte, MSB first,
// on the LEDs and two hex digits. Define FPADD_DISP_DP_INDEX_EN to drive the decimal points with the byte index.
module fpadd_result_display #(
  parameter int DEPTH = 4,
  parameter int DWELL = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  output logic        res_ready,
  output logic [7:0]  leds,
  output logic        an0,
  output logic        a0, b0, c0, d0, e0, f0, g0,
  output logic        fp0,
  output logic        an1,
  output logic        a1, b1, c1, d1, e1, f1, g1,
  output logic        fp1,
  output logic        busy
);

  // Handshake: a word transfers on a rising clk edge where res_valid & res_ready are both high;
  // res_ready depends only on the registered FIFO count, never on res_valid.

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2} state_t;

  state_t          state, next_state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic [31:0]     word;
  logic [1:0]      idx;
  logic [DW-1:0]   dwell;
  logic            push, pop, dwell_end;

  logic            disp_upd, disp_off;
  logic [1:0]      disp_idx;
  logic [7:0]      disp_byte;
  logic [6:0]      seg0_q, seg1_q;
  logic            an_q;

  assign res_ready = (count != (AW+1)'(DEPTH));
  assign push      = res_valid & res_ready;
  assign pop       = (state == LOAD);
  assign busy      = (state != IDLE) | (count != '0);
  assign dwell_end = (dwell == DW'(DWELL - 1));

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)   // {a,b,c,d,e,f,g}
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // FIFO storage carries no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= res_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (count != '0) next_state = LOAD;
      LOAD:    next_state = SHOW;
      SHOW:    if (dwell_end && idx == 2'd0) next_state = (count != '0) ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      idx   <= 2'd3;
      dwell <= '0;
    end else if (state == LOAD) begin
      word  <= mem[rptr];
      idx   <= 2'd3;
      dwell <= '0;
    end else if (state == SHOW) begin
      if (dwell_end) begin
        dwell <= '0;
        if (idx != 2'd0) idx <= idx - 2'd1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Display values are computed one cycle ahead so the pins change on the same edge as idx.
  always_comb begin
    disp_upd  = 1'b0;
    disp_off  = 1'b0;
    disp_idx  = 2'd3;
    disp_byte = mem[rptr][31:24];
    case (state)
      LOAD: disp_upd = 1'b1;
      SHOW: begin
        if (dwell_end) begin
          if (idx != 2'd0) begin
            disp_upd  = 1'b1;
            disp_idx  = idx - 2'd1;
            disp_byte = word[{disp_idx, 3'b000} +: 8];
          end else if (next_state == IDLE) begin
            disp_off = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds   <= '0;
      an_q   <= 1'b0;
      seg0_q <= '0;
      seg1_q <= '0;
    end else if (disp_upd) begin
      leds   <= disp_byte;
      an_q   <= 1'b1;
      seg1_q <= hex7(disp_byte[7:4]);
      seg0_q <= hex7(disp_byte[3:0]);
    end else if (disp_off) begin
      an_q   <= 1'b0;
      seg0_q <= '0;
      seg1_q <= '0;
    end
  end

  assign an0 = an_q;
  assign an1 = an_q;
  assign {a0, b0, c0, d0, e0, f0, g0} = seg0_q;
  assign {a1, b1, c1, d1, e1, f1, g1} = seg1_q;

`ifdef FPADD_DISP_DP_INDEX_EN
  logic [1:0] dp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           dp_q <= '0;
    else if (disp_upd) dp_q <= disp_idx;
    else if (disp_off) dp_q <= '0;
  end

  assign fp1 = dp_q[1];
  assign fp0 = dp_q[0];
`else
  assign fp1 = 1'b0;
  assign fp0 = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_result_display.sv
// Bench for fpadd_result_display: scoreboard of expected display bytes, fed on each accepted word,
// consumed by a negedge monitor that follows the fixed DWELL byte schedule.
module tb_fpadd_result_display;
  localparam int DEPTH = 4;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_ready, an0, an1, fp0, fp1, busy;
  logic        a0, b0, c0, d0, e0, f0, g0;
  logic        a1, b1, c1, d1, e1, f1, g1;
  logic [7:0]  leds;

  fpadd_result_display #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .leds(leds),
    .an0(an0), .a0(a0), .b0(b0), .c0(c0), .d0(d0), .e0(e0), .f0(f0), .g0(g0), .fp0(fp0),
    .an1(an1), .a1(a1), .b1(b1), .c1(c1), .d1(d1), .e1(e1), .f1(f1), .g1(g1), .fp1(fp1),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  string seg_tab[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    string s;
    logic [6:0] v;
    s = seg_tab[n];
    v = '0;
    for (int i = 0; i < s.len(); i++) v[6 - (int'(s[i]) - 97)] = 1'b1;
    return v;
  endfunction

  wire [6:0] seg1 = {a1, b1, c1, d1, e1, f1, g1};
  wire [6:0] seg0 = {a0, b0, c0, d0, e0, f0, g0};

  // ---------------- scoreboard + monitor ----------------
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc = 0;
  bit         mon_act = 1'b0;
  bit         mon_in_load = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] cur_b = '0;
  logic [1:0] exp_fp;

  always @(negedge clk) begin
    cyc++;
    mon_in_load = 1'b0;
    if (rst) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act && an1) begin
        mon_act = 1'b1;
        mon_cyc = 0;
      end
      if (mon_act) begin
        if (mon_cyc < 4 * DWELL) begin
          if (mon_cyc % DWELL == 0) begin
            if (mon_cyc == 0) start_q.push_back(cyc);
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) cur_b = exp_q.pop_front();
`ifdef FPADD_DISP_DP_INDEX_EN
            exp_fp = 2'(3 - mon_cyc / DWELL);
`else
            exp_fp = 2'd0;
`endif
            check("byte", leds, cur_b);
            check("an", {an1, an0}, 2'b11);
            check("seg1", seg1, seg_of(cur_b[7:4]));
            check("seg0", seg0, seg_of(cur_b[3:0]));
            check("fp", {fp1, fp0}, exp_fp);
          end else begin
            check("byte_hold", leds, cur_b);
          end
          mon_cyc++;
        end else if (an1) begin
          check("load_hold", leds, cur_b);
          mon_in_load = 1'b1;
          mon_cyc = 0;
        end else begin
          check("idle_an0", an0, 0);
          check("idle_segs", {seg1, seg0}, 0);
          check("idle_fp", {fp1, fp0}, 0);
          check("idle_leds", leds, cur_b);
          mon_act = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called between edges; returns #1 after the accepting edge.
  task automatic push_word(input logic [31:0] w, output int waits);
    bit rdy;
    waits = 0;
    res_valid = 1'b1;
    res_data  = w;
    forever begin
      rdy = res_ready;
      @(posedge clk);
      waits++;
      if (rdy) break;
      if (waits > 500) break;
      #1;
    end
    if (rdy) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    end
    check("push_accepted", 32'(rdy), 1);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      #1;
      if (!busy && !mon_act && exp_q.size() == 0) done = 1'b1;
    end
    check("drain", 32'(done), 1);
  endtask

  task automatic wait_load();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      #1;
      if (mon_in_load) seen = 1'b1;
    end
    check("load_seen", 32'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  int          w;
  int          waits6[6];
  logic [31:0] words6[6] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
                             32'h0F1E2D3C, 32'h4B5A6978};
  bit          seen_c0, resumed;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", leds, 0);
    check("rst_an", {an1, an0}, 0);
    check("rst_segs", {seg1, seg0}, 0);
    check("rst_fp", {fp1, fp0}, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", res_ready, 1);

    // single word, latency and idle return
    push_word(32'h3FC00000, w);
    @(negedge clk); check("lat_e0_an1", an1, 0);
    @(negedge clk); check("lat_e1_an1", an1, 0); check("lat_e1_busy", busy, 1);
    @(negedge clk); check("lat_e2_an1", an1, 1); check("lat_e2_leds", leds, 8'h3F);
    check("seg1_3", seg1, 7'b1111001);
    check("seg0_f", seg0, 7'b1000111);
    drain();
    check("end_an", {an1, an0}, 0);
    check("end_busy", busy, 0);
    check("end_leds", leds, 8'h00);

    // nibble decode sweep
    push_word(32'h0123ABCD, w);
    drain();
    check("hold_leds", leds, 8'hCD);

    // back-pressure: valid held for 6 words
    for (int i = 0; i < 6; i++) push_word(words6[i], waits6[i]);
    for (int i = 0; i < 5; i++) check("bp_wait_free", waits6[i], 1);
    check("bp_wait_full", waits6[5], 4 * DWELL);
    drain();

    // one push on every LOAD cycle keeps the stream gapless
    start_q.delete();
    push_word(32'h40490FDB, w);
    push_word(32'hC0A00001, w);
    for (int k = 0; k < 3; k++) begin
      wait_load();
      push_word(32'h12340000 + 32'(k), w);
      check("load_push_wait", w, 1);
    end
    drain();
    check("stream_words", start_q.size(), 5);
    for (int i = 1; i < start_q.size(); i++)
      check("stream_period", start_q[i] - start_q[i-1], 4 * DWELL + 1);

    // random words with random gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      #1;
      push_word($urandom, w);
    end
    drain();

    // reset in the middle of byte C0 with two words queued
    push_word(32'h3FC00000, w);
    push_word(32'hAAAAAAAA, w);
    push_word(32'h55555555, w);
    seen_c0 = 1'b0;
    for (int t = 0; t < 100 && !seen_c0; t++) begin
      @(negedge clk);
      if (an1 && leds == 8'hC0) seen_c0 = 1'b1;
    end
    check("c0_seen", 32'(seen_c0), 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_leds", leds, 0);
    check("arst_an", {an1, an0}, 0);
    check("arst_segs", {seg1, seg0}, 0);
    check("arst_fp", {fp1, fp0}, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_ready", res_ready, 1);
    resumed = 1'b0;
    for (int t = 0; t < 20 * DWELL; t++) begin
      @(negedge clk);
      if (an1 || busy || leds != 8'h00) resumed = 1'b1;
    end
    check("no_resume", 32'(resumed), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpadd_result_display.md
Name: fpadd_result_display

Overview:
- Consumer end of the FP adder result path. Accepts 32-bit FP results over a valid/ready handshake and buffers them in a small FIFO.
- Presents each buffered result byte by byte, MSB first, on the two hex seven-segment digits and on the 8 LEDs.
- Each byte is held for a programmable dwell time.
- Sits between the adder pipeline output and the board display pins inside fpadd_system.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of 2, >= 2
- DWELL, 50000000, cycles each byte is displayed; >= 1 (benches use 4)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- res_valid  in  1  result word present on res_data
- res_data  in  32  IEEE-754 single result
- res_ready  out  1  FIFO can accept; transfer when res_valid & res_ready at clk edge
- leds  out  8  byte currently displayed
- an0  out  1  digit 0 (low nibble) enable, active-high
- a0,b0,c0,d0,e0,f0,g0  out  1 each  digit 0 segments, active-high
- fp0  out  1  digit 0 decimal point
- an1  out  1  digit 1 (high nibble) enable, active-high
- a1,b1,c1,d1,e1,f1,g1  out  1 each  digit 1 segments, active-high
- fp1  out  1  digit 1 decimal point
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, immediate):
  - FIFO pointers and count cleared; FSM to IDLE; byte index 3; dwell counter 0.
  - leds=0; all segments, fp0/fp1, an0/an1 = 0; busy=0; res_ready=1 once rst deasserts.
  - Reset mid-display discards buffered and in-flight words; nothing resumes.
- FIFO:
  - res_ready = (count != DEPTH), driven combinationally from registered count.
  - Push when res_valid & res_ready.
  - Pop only in LOAD. A simultaneous push and pop leaves count unchanged.
  - When full, a same-cycle pop does not make res_ready high in that cycle.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
- FSM:
  - IDLE: an0=an1=0, segments 0, leds hold last value. Goes to LOAD when count != 0.
  - LOAD: 1 cycle. Latch head word, pop, idx=3, dwell=0. Go to SHOW. Outputs hold their previous values during LOAD.
  - SHOW: byte = word[8*idx+7 : 8*idx].
    - leds=byte; an0=an1=1; digit1=hex(byte[7:4]); digit0=hex(byte[3:0]).
    - Dwell counter runs 0..DWELL-1. At DWELL-1: if idx>0, decrement idx and clear dwell.
    - If idx==0: go to LOAD if count != 0, else IDLE.
- Latency:
  - Word accepted at edge E into an empty, idle block: LOAD at E+1, SHOW at E+2.
  - Byte 3 is visible on outputs registered at E+2.
  - Each byte is visible for exactly DWELL cycles.
  - Streaming period is 4*DWELL+1 cycles per word.
- Hex decode, segments a-g active-high:
  - 0 = abcdef
  - 1 = bc
  - 2 = abdeg
  - 3 = abcdg
  - 4 = bcfg
  - 5 = acdfg
  - 6 = acdefg
  - 7 = abc
  - 8 = abcdefg
  - 9 = abcdfg
  - A = abcefg
  - b = cdefg
  - C = adef
  - d = bcdeg
  - E = adefg
  - F = aefg
- All display outputs are registered; there are no combinational paths from res_data to the pins.
- busy = (state != IDLE) | (count != 0).

Optional Feature:
- Macro: FPADD_DISP_DP_INDEX_EN
- Defined: in SHOW, fp1=idx[1] and fp0=idx[0], so the decimal points show which byte is displayed (3 = both on). In IDLE both are 0.
- Not defined: fp0 and fp1 are tied to 0 and no index logic reaches them.

Test Plan:
- Push 0x3FC00000 (DWELL=4), no further pushes:
  - leds sequence 3F, C0, 00, 00, each for 4 cycles.
  - Byte 3F: digit1 a,b,c,d,g=1 and e,f=0; digit0 a,e,f,g=1.
  - Then IDLE, an0=an1=0, busy=0.
- DEPTH=4, hold res_valid for 6 words while displaying:
  - res_ready drops after 5 accepted (4 buffered + 1 latched).
  - Re-rises 1 cycle after the next LOAD.
  - All 6 words are displayed in order.
- Push a word on every LOAD cycle:
  - count stays constant, no gap beyond the 1-cycle LOAD between words.
  - Period is 17 cycles.
- Assert rst mid-SHOW of byte C0 with 2 words queued:
  - Outputs go to 0 immediately, asynchronously; busy=0.
  - After release, no further bytes are displayed.
- With FPADD_DISP_DP_INDEX_EN, push 0x40490FDB:
  - (fp1,fp0) = 11, 10, 01, 00 across bytes 40, 49, 0F, DB.
  - Without the macro, fp0=fp1=0 throughout.
- Push 0x0123ABCD:
  - Check decode of all 8 distinct nibbles against the table.
